// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word read or byte-enabled write per
// valid/ready request, answered after LATENCY cycles on a held response channel.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Handshakes: a beat transfers at a rising edge where valid && ready.
    // req_ready is high only in IDLE; rsp_valid is high only in RESP and the
    // response payload is frozen there until rsp_ready is seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit         DIRECT = (LATENCY == 1);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [31:0] mem [2**ADDR_W];

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept, access;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic [ADDR_W-1:0] acc_idx;
    logic        mem_wr;

    logic [31:0] rdata_q;
    logic        err_q;

    // With a single-cycle latency the access uses the request as it is accepted.
    assign acc_we    = DIRECT ? req_we    : lat_we;
    assign acc_addr  = DIRECT ? req_addr  : lat_addr;
    assign acc_wdata = DIRECT ? req_wdata : lat_wdata;
    assign acc_be    = DIRECT ? req_be    : lat_be;
    assign acc_idx   = acc_addr[ADDR_W+1:2];
    assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    assign mem_wr    = access && acc_we && !acc_err && !reset;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (DIRECT) begin
                        access     = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = LAT_M1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // The access fires on the edge that takes the counter to zero.
                if (cnt != 4'd0) cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (access) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // The array is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = !reset && (state == IDLE);
    assign rsp_valid = !reset && (state == RESP);
    assign rsp_rdata = reset ? 32'd0 : rdata_q;
    assign rsp_err   = !reset && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three builds (LATENCY 2, 3 and 1) share
// one clock and reset; each scenario task checks its own expectations inline.
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut_l3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Full transaction on instance k with rsp_ready=1. Called just after a
    // rising edge; returns just after the response handshake edge.
    // lat = cycles from accept edge to first rsp_valid (0 on timeout).
    task automatic txn(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rdata, output logic err, output int lat);
        int c;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        rsp_ready[k] = 1'b1;
        rdata = 32'd0;
        err   = 1'b0;
        lat   = 0;
        c = 0;
        @(negedge clock);
        while (req_ready[k] !== 1'b1 && c < 50) begin
            c++;
            @(negedge clock);
        end
        checks++;
        if (c >= 50) begin
            failures++;
            $display("FAIL txn_accept_timeout inst=%0d addr=%08h", k, addr);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clock);
        #1 req_valid[k] = 1'b0;
        lat = 1;
        @(negedge clock);
        while (rsp_valid[k] !== 1'b1 && lat < 50) begin
            lat++;
            @(negedge clock);
        end
        checks++;
        if (lat >= 50) begin
            failures++;
            $display("FAIL txn_rsp_timeout inst=%0d addr=%08h", k, addr);
            lat = 0;
            return;
        end
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b0 || rsp_valid[k] !== 1'b0 ||
                rsp_rdata[k] !== 32'd0 || rsp_err[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got rr=%b rv=%b rd=%08h err=%b want 0 0 0 0",
                         k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k]);
            end
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release inst=%0d got rr=%b rv=%b want rr=1 rv=0",
                         k, req_ready[k], rsp_valid[k]);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_read_latency();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        exp_rv, exp_rr;
        txn(0, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h10;
        rsp_ready[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL lat_idle_ready got %b want 1", req_ready[0]);
        end
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            exp_rv = (i == 2);
            exp_rr = (i == 3);
            checks++;
            if (rsp_valid[0] !== exp_rv || req_ready[0] !== exp_rr) begin
                failures++;
                $display("FAIL lat_timing cycle=T+%0d got rv=%b rr=%b want rv=%b rr=%b",
                         i, rsp_valid[0], req_ready[0], exp_rv, exp_rr);
            end
            if (i == 2) begin
                checks++;
                if (rsp_rdata[0] !== 32'hCAFE_F00D || rsp_err[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL lat_rdata got %08h err=%b want cafef00d err=0",
                             rsp_rdata[0], rsp_err[0]);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL wr_full_rsp got rd=%08h err=%b lat=%0d want 0 0 2", rd, er, lat);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            failures++;
            $display("FAIL rd_after_full got %08h err=%b want deadbeef err=0", rd, er);
        end
        txn(0, 1'b1, 32'h20, 32'h0000_00AA, 4'b0001, rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEAA) begin
            failures++;
            $display("FAIL rd_after_be0001 got %08h want deadbeaa", rd);
        end
        txn(0, 1'b1, 32'h20, 32'h5566_7788, 4'b1010, rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h55AD_77AA) begin
            failures++;
            $display("FAIL rd_after_be1010 got %08h want 55ad77aa", rd);
        end
        txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h55AD_77AA) begin
            failures++;
            $display("FAIL rd_after_be0000 got %08h want 55ad77aa", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(0, 1'b1, 32'h0, 32'h0BAD_C0DE, 4'hF, rd, er, lat);
        txn(0, 1'b1, 32'h22, 32'h1111_1111, 4'hF, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_misaligned_wr got err=%b rd=%08h want 1 0", er, rd);
        end
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_misaligned_rd got err=%b rd=%08h want 1 0", er, rd);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h55AD_77AA || er !== 1'b0) begin
            failures++;
            $display("FAIL err_misaligned_nochange got %08h err=%b want 55ad77aa 0", rd, er);
        end
        txn(0, 1'b1, 32'h0000_1000, 32'h2222_2222, 4'hF, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_range_wr got err=%b rd=%08h want 1 0", er, rd);
        end
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0BAD_C0DE || er !== 1'b0) begin
            failures++;
            $display("FAIL err_range_nochange got %08h err=%b want 0badc0de 0", rd, er);
        end
        txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_range_highbit got err=%b rd=%08h want 1 0", er, rd);
        end
    endtask

    task automatic test_back_pressure();
        int c;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h20;
        rsp_ready[0] = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1 req_addr[0] = 32'h10;
        c = 0;
        @(negedge clock);
        while (rsp_valid[0] !== 1'b1 && c < 20) begin
            c++;
            @(negedge clock);
        end
        checks++;
        if (c >= 20) begin
            failures++;
            $display("FAIL bp_rsp_timeout");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h55AD_77AA || req_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got rv=%b rd=%08h rr=%b want 1 55ad77aa 0",
                         i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
            end
        end
        @(posedge clock);
        #1 rsp_ready[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_pre_handshake got rv=%b rr=%b want 1 0", rsp_valid[0], req_ready[0]);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_after_handshake got rr=%b rv=%b want 1 0", req_ready[0], rsp_valid[0]);
        end
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_wait got rv=%b want 0", rsp_valid[0]);
        end
        @(negedge clock);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL bp_second_rsp got rv=%b rd=%08h want 1 cafef00d", rsp_valid[0], rsp_rdata[0]);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF, rd, er, lat);
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL l3_latency got %0d want 3", lat);
        end
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'hFFFF_FFFF;
        req_be[1]    = 4'hF;
        @(negedge clock);
        @(posedge clock);
        #1 req_valid[1] = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0 ||
            rsp_rdata[1] !== 32'd0 || rsp_err[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got rr=%b rv=%b rd=%08h err=%b want 0 0 0 0",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_release got rr=%b rv=%b want 1 0", req_ready[1], rsp_valid[1]);
        end
        @(posedge clock);
        #1;
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_array got %08h err=%b want 12345678 0", rd, er);
        end
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL array_survives_reset got %08h want cafef00d", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(2, 1'b1, 32'h0, 32'h0000_0011, 4'hF, rd, er, lat);
        txn(2, 1'b1, 32'h4, 32'h0000_0022, 4'hF, rd, er, lat);
        txn(2, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (lat != 1 || rd !== 32'h0000_0022) begin
            failures++;
            $display("FAIL l1_raw got lat=%0d rd=%08h want 1 00000022", lat, rd);
        end
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 32'h0;
        rsp_ready[2] = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready[2] !== 1'b1) begin
            failures++;
            $display("FAIL l1_first_ready got %b want 1", req_ready[2]);
        end
        @(posedge clock);
        #1 req_addr[2] = 32'h4;
        @(negedge clock);
        checks++;
        if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== 32'h0000_0011 || req_ready[2] !== 1'b0) begin
            failures++;
            $display("FAIL l1_first_rsp got rv=%b rd=%08h rr=%b want 1 00000011 0",
                     rsp_valid[2], rsp_rdata[2], req_ready[2]);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL l1_second_ready got rr=%b rv=%b want 1 0", req_ready[2], rsp_valid[2]);
        end
        @(posedge clock);
        #1 req_valid[2] = 1'b0;
        @(negedge clock);
        checks++;
        if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== 32'h0000_0022) begin
            failures++;
            $display("FAIL l1_second_rsp got rv=%b rd=%08h want 1 00000022", rsp_valid[2], rsp_rdata[2]);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
            req_be[k]    = 4'd0;
            rsp_ready[k] = 1'b0;
        end
        test_reset();
        test_read_latency();
        test_write_read();
        test_errors();
        test_back_pressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
